// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: two debounced keys select and launch one ALU operation.
// Ports: clk, rst_n, btn_change/btn_exec (raw active-low keys), sw_z/sw_y
//   operands, alu_result/alu_flags from the ALU; op_sel, alu_a, alu_b and
//   start to the ALU; mode, result_q, flags_q, busy, done for display.
module alu_op_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int NUM_OPS         = 12,
   parameter int ALU_LATENCY     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_change,
   input  logic       btn_exec,
   input  logic [3:0] sw_z,
   input  logic [3:0] sw_y,
   input  logic [3:0] alu_result,
   input  logic [3:0] alu_flags,
   output logic [3:0] op_sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       start,
   output logic [3:0] mode,
   output logic [3:0] result_q,
   output logic [3:0] flags_q,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_WAIT,
      S_SHOW
   } state_e;

   localparam int DCW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DCW-1:0] DLAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);
   localparam logic [3:0] WLOAD = 4'(ALU_LATENCY - 1);

   // Index 0 is the change key, index 1 the exec key.
   logic [1:0]          sync1_q, sync1_d;
   logic [1:0]          sync2_q, sync2_d;
   logic [1:0]          db_q, db_d;
   logic [1:0][DCW-1:0] dcnt_q, dcnt_d;
   logic [1:0]          press;

   state_e     state_q, state_d;
   logic [3:0] mode_q, mode_d;
   logic [3:0] op_sel_q, op_sel_d;
   logic [3:0] alu_a_q, alu_a_d;
   logic [3:0] alu_b_q, alu_b_d;
   logic [3:0] result_d;
   logic [3:0] flags_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic [3:0] mode_inc;

   always_comb begin
      sync1_d = {btn_exec, btn_change};
      sync2_d = sync1_q;
      for (int i = 0; i < 2; i++) begin
         db_d[i]   = db_q[i];
         dcnt_d[i] = '0;
         press[i]  = 1'b0;
         // Count consecutive samples that disagree with the accepted
         // level; any agreeing sample restarts the count.
         if (sync2_q[i] != db_q[i]) begin
            if (dcnt_q[i] == DLAST) begin
               db_d[i]  = sync2_q[i];
               // Press is decoded from flops, so it is clean and lasts
               // exactly the cycle before the level flips.
               press[i] = ~sync2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      mode_inc = (mode_q == LAST_OP) ? 4'd0 : mode_q + 4'd1;
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      op_sel_d = op_sel_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      result_d = result_q;
      flags_d  = flags_q;
      wcnt_d   = wcnt_q;
      start    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         S_IDLE, S_SHOW: begin
            done = (state_q == S_SHOW);
            // Exec has priority; a coincident change is dropped.
            if (press[1]) begin
               state_d = S_LOAD;
            end else if (press[0]) begin
               mode_d  = mode_inc;
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            busy     = 1'b1;
            op_sel_d = mode_q;
            alu_a_d  = sw_z;
            alu_b_d  = sw_y;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            busy    = 1'b1;
            start   = 1'b1;
            wcnt_d  = WLOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wcnt_q == 4'd0) begin
               result_d = alu_result;
               flags_d  = alu_flags;
               state_d  = S_SHOW;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         db_q     <= 2'b11;
         dcnt_q   <= '0;
         state_q  <= S_IDLE;
         mode_q   <= 4'd0;
         op_sel_q <= 4'd0;
         alu_a_q  <= 4'd0;
         alu_b_q  <= 4'd0;
         result_q <= 4'd0;
         flags_q  <= 4'd0;
         wcnt_q   <= 4'd0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_q     <= db_d;
         dcnt_q   <= dcnt_d;
         state_q  <= state_d;
         mode_q   <= mode_d;
         op_sel_q <= op_sel_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         wcnt_q   <= wcnt_d;
      end
   end

   assign mode   = mode_q;
   assign op_sel = op_sel_q;
   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer
//   against a behavioural mode/ALU model; ALU modelled as a + b.
module tb_alu_op_sequencer;

   localparam int D = 4;
   localparam int N = 12;
   localparam int L = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_change = 1'b1;
   logic       btn_exec = 1'b1;
   logic [3:0] sw_z = 4'd0;
   logic [3:0] sw_y = 4'd0;
   logic [3:0] alu_result = 4'd0;
   logic [3:0] alu_flags = 4'd0;
   logic [3:0] op_sel, alu_a, alu_b, mode, result_q, flags_q;
   logic       start, busy, done;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   int rem = -1;
   bit done_seen = 1'b0;
   logic [4:0] pend = 5'd0;

   alu_op_sequencer #(
      .DEBOUNCE_CYCLES(D),
      .NUM_OPS(N),
      .ALU_LATENCY(L)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_change(btn_change),
      .btn_exec(btn_exec),
      .sw_z(sw_z),
      .sw_y(sw_y),
      .alu_result(alu_result),
      .alu_flags(alu_flags),
      .op_sel(op_sel),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .start(start),
      .mode(mode),
      .result_q(result_q),
      .flags_q(flags_q),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] flag_fn(logic [4:0] s);
      return {s[3], s[3:0] == 4'd0, s[4], 1'b0};
   endfunction

   // ALU model: result valid L cycles after the start cycle, junk before.
   always @(negedge clk) begin
      if (start) begin
         start_cnt++;
         rem = L;
         pend = {1'b0, alu_a} + {1'b0, alu_b};
      end else if (rem > 0) begin
         rem--;
      end
      if (rem == 0) begin
         alu_result = pend[3:0];
         alu_flags = flag_fn(pend);
      end else begin
         alu_result = 4'($urandom);
         alu_flags = 4'($urandom);
      end
      if (done) done_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mode"}, mode, 0);
      chk({tag, "_op_sel"}, op_sel, 0);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_result"}, result_q, 0);
      chk({tag, "_flags"}, flags_q, 0);
      chk({tag, "_start"}, start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic press_change();
      btn_change = 1'b0;
      tick(3 * D + 4);
      btn_change = 1'b1;
      tick(D + 6);
   endtask

   // Press exec and count edges until done follows a busy phase.
   task automatic run_exec(output int lat);
      bit seen = 1'b0;
      lat = 0;
      btn_exec = 1'b0;
      while (lat < 200) begin
         tick(1);
         lat++;
         if (busy) seen = 1'b1;
         if (seen && done) break;
      end
      btn_exec = 1'b1;
      tick(D + 6);
   endtask

   initial begin
      int mode_m;
      int lat;
      int sc;
      logic [3:0] z, y;
      logic [4:0] s;

      mode_m = 0;
      tick(3);
      chk_zero("reset");
      rst_n = 1'b1;
      tick(3);
      chk_zero("post_reset");

      // Precise press-to-increment latency on the first press.
      btn_change = 1'b0;
      tick(D + 1);
      chk("chg_lat_before", mode, 0);
      tick(1);
      chk("chg_lat_at", mode, 1);
      tick(2 * D);
      btn_change = 1'b1;
      tick(D + 6);
      mode_m = 1;
      for (int i = 1; i < N; i++) begin
         press_change();
         mode_m = (mode_m + 1) % N;
         chk($sformatf("press_%0d", i), mode, mode_m);
      end
      chk("wrap_to_zero", mode, 0);

      // Bouncing glitch shorter than the debounce window.
      for (int b = 0; b < 3; b++) begin
         btn_change = 1'b0;
         tick(D - 1);
         btn_change = 1'b1;
         tick(1);
      end
      tick(D + 6);
      chk("glitch_mode", mode, mode_m);

      press_change();
      mode_m = (mode_m + 1) % N;
      chk("mode_one", mode, 1);
      sw_z = 4'h5;
      sw_y = 4'h3;
      sc = start_cnt;
      run_exec(lat);
      chk("exec_latency", lat, 4 + D + L);
      chk("exec_op_sel", op_sel, 1);
      chk("exec_result", result_q, 4'h8);
      chk("exec_flags", flags_q, flag_fn(5'd8));
      chk("exec_starts", start_cnt - sc, 1);
      chk("exec_done", done, 1);

      // Change pulse lands in WAIT and must be ignored.
      sw_z = 4'h9;
      sw_y = 4'h2;
      btn_exec = 1'b0;
      tick(3);
      btn_change = 1'b0;
      lat = 0;
      while (!(done && !busy && lat > 5) && lat < 200) begin
         tick(1);
         lat++;
      end
      btn_exec = 1'b1;
      btn_change = 1'b1;
      tick(D + 6);
      chk("wait_chg_mode", mode, mode_m);
      chk("wait_chg_done", done, 1);
      chk("wait_chg_result", result_q, 4'hB);
      press_change();
      mode_m = (mode_m + 1) % N;
      chk("show_chg_mode", mode, mode_m);
      chk("show_chg_done", done, 0);
      chk("show_chg_busy", busy, 0);

      while (mode_m != 11) begin
         press_change();
         mode_m = (mode_m + 1) % N;
      end
      chk("mode_eleven", mode, 11);
      sw_z = 4'h7;
      sw_y = 4'hC;
      btn_exec = 1'b0;
      btn_change = 1'b0;
      lat = 0;
      while (!(done && lat > 5) && lat < 200) begin
         tick(1);
         lat++;
      end
      btn_exec = 1'b1;
      btn_change = 1'b1;
      tick(D + 6);
      chk("tie_op_sel", op_sel, 11);
      chk("tie_mode", mode, 11);
      chk("tie_result", result_q, 4'h3);

      // Reset in WAIT aborts the operation.
      sc = start_cnt;
      btn_exec = 1'b0;
      lat = 0;
      while (start_cnt == sc && lat < 200) begin
         tick(1);
         lat++;
      end
      chk("rst_saw_start", start_cnt - sc, 1);
      btn_exec = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_zero("rst_async");
      tick(3);
      rst_n = 1'b1;
      done_seen = 1'b0;
      sc = start_cnt;
      tick(30);
      chk("rst_no_start", start_cnt - sc, 0);
      chk("rst_no_done", done_seen, 0);
      chk_zero("rst_after");
      mode_m = 0;

      // Key held low across reset release still presses once.
      rst_n = 1'b0;
      btn_change = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(D + 8);
      btn_change = 1'b1;
      tick(D + 6);
      mode_m = 1;
      chk("held_reset_mode", mode, mode_m);

      for (int it = 0; it < 6; it++) begin
         int k;
         k = int'($urandom_range(0, 3));
         for (int p = 0; p < k; p++) begin
            press_change();
            mode_m = (mode_m + 1) % N;
         end
         z = 4'($urandom);
         y = 4'($urandom);
         s = {1'b0, z} + {1'b0, y};
         sw_z = z;
         sw_y = y;
         sc = start_cnt;
         run_exec(lat);
         chk($sformatf("rnd%0d_op_sel", it), op_sel, mode_m);
         chk($sformatf("rnd%0d_a", it), alu_a, z);
         chk($sformatf("rnd%0d_b", it), alu_b, y);
         chk($sformatf("rnd%0d_result", it), result_q, s[3:0]);
         chk($sformatf("rnd%0d_flags", it), flags_q, flag_fn(s));
         chk($sformatf("rnd%0d_starts", it), start_cnt - sc, 1);
         chk($sformatf("rnd%0d_mode", it), mode, mode_m);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
